// File: rtl/spi_pixel_loader.sv
// -----------------------------------------------------------------------------
// spi_pixel_loader
//
// Producer side of the SPI image-write handshake. Bytes arriving from the SPI
// slave are paired into big-endian 16-bit pixels, tagged with raster
// coordinates starting at (0,0), and buffered in a small FIFO. The head of
// the FIFO is presented to the SRAM wrapper one pixel at a time and held
// until the wrapper acknowledges the write with spi_pixel_read.
//
// Ports
//   clk              in   system clock, all logic on posedge
//   rst_n            in   asynchronous active-low reset
//   spi_frame_start  in   pulse: new image begins (flushes everything)
//   spi_byte_valid   in   pulse: spi_byte holds a received byte
//   spi_byte         in   received byte
//   spi_pixel_ready  out  presented pixel/coordinates are valid
//   spi_pixel_read   in   pulse: wrapper has written the presented pixel
//   spi_pixel_data   out  presented pixel value
//   spi_pixel_x      out  signed x of presented pixel (never negative)
//   spi_pixel_y      out  signed y of presented pixel (never negative)
//   image_done       out  whole image received and acknowledged
//   overflow         out  sticky: a pixel was dropped on a full FIFO
// -----------------------------------------------------------------------------
module spi_pixel_loader #(
  parameter int X_RES      = 800,
  parameter int Y_RES      = 600,
  parameter int PRECISION  = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_GUARD  = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        spi_frame_start,
  input  logic                        spi_byte_valid,
  input  logic [7:0]                  spi_byte,
  output logic                        spi_pixel_ready,
  input  logic                        spi_pixel_read,
  output logic [15:0]                 spi_pixel_data,
  output logic signed [PRECISION:0]   spi_pixel_x,
  output logic signed [PRECISION:0]   spi_pixel_y,
  output logic                        image_done,
  output logic                        overflow
);

  localparam int CW = PRECISION;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int GW = $clog2(ACK_GUARD + 1);
  localparam int EW = 16 + 2 * CW;

  localparam logic [CW-1:0] X_LAST     = CW'(X_RES - 1);
  localparam logic [CW-1:0] Y_LAST     = CW'(Y_RES - 1);
  localparam logic [PW:0]   FIFO_FULL  = (PW + 1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(ACK_GUARD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Assembler and coordinate state
  state_e          state_q, state_d;
  logic [7:0]      hi_q, hi_d;
  logic [CW-1:0]   x_q, x_d;
  logic [CW-1:0]   y_q, y_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;

  // Presentation registers
  logic            ready_q, ready_d;
  logic [15:0]     data_q, data_d;
  logic [CW-1:0]   px_q, px_d;
  logic [CW-1:0]   py_q, py_d;

  // FIFO
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;

  logic            push_s;
  logic            pop_s;
  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic [EW-1:0]   push_entry_s;
  logic [EW-1:0]   head_s;
  logic            at_x_last_s;
  logic            at_last_pixel_s;
  logic            guard_clear_s;

  assign fifo_empty_s    = (count_q == '0);
  // Full is judged on occupancy before any same-cycle pop: no bypass.
  assign fifo_full_s     = (count_q == FIFO_FULL);
  assign head_s          = mem_q[rd_ptr_q];
  assign push_entry_s    = {hi_q, spi_byte, x_q, y_q};
  assign at_x_last_s     = (x_q == X_LAST);
  assign at_last_pixel_s = at_x_last_s && (y_q == Y_LAST);
  assign guard_clear_s   = (guard_q == '0);

  // Next-state logic for assembler, coordinates, FIFO control and output stage
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    x_d        = x_q;
    y_d        = y_q;
    guard_d    = guard_q;
    overflow_d = overflow_q;
    done_d     = done_q;
    ready_d    = ready_q;
    data_d     = data_q;
    px_d       = px_q;
    py_d       = py_q;
    push_s     = 1'b0;
    pop_s      = 1'b0;

    if (spi_frame_start) begin
      // A new frame wins over everything, including a byte in the same cycle.
      state_d    = ST_HI;
      x_d        = '0;
      y_d        = '0;
      guard_d    = GUARD_LOAD;
      overflow_d = 1'b0;
      done_d     = 1'b0;
      ready_d    = 1'b0;
    end else begin
      if (!guard_clear_s) begin
        guard_d = guard_q - GW'(1);
      end else begin
        guard_d = guard_q;
      end

      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_HI: begin
          if (spi_byte_valid) begin
            hi_d    = spi_byte;
            state_d = ST_LO;
          end else begin
            state_d = ST_HI;
          end
        end
        ST_LO: begin
          if (spi_byte_valid) begin
            if (fifo_full_s) begin
              overflow_d = 1'b1;
            end else begin
              push_s = 1'b1;
            end
            // Coordinates advance whether or not the pixel was kept.
            if (at_x_last_s) begin
              x_d = '0;
              y_d = y_q + CW'(1);
            end else begin
              x_d = x_q + CW'(1);
            end
            if (at_last_pixel_s) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_HI;
            end
          end else begin
            state_d = ST_LO;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Acks during the guard window may belong to the flushed frame.
      if (ready_q) begin
        if (spi_pixel_read && guard_clear_s) begin
          ready_d = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end else if (!fifo_empty_s && guard_clear_s) begin
        pop_s   = 1'b1;
        ready_d = 1'b1;
        data_d  = head_s[EW-1 -: 16];
        px_d    = head_s[2*CW-1 -: CW];
        py_d    = head_s[CW-1:0];
      end else begin
        ready_d = 1'b0;
      end

      done_d = (state_q == ST_DONE) && fifo_empty_s && !ready_q;
    end
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (spi_frame_start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + (PW + 1)'(1);
        2'b01:   count_d = count_q - (PW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Assembler, coordinate and output-stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hi_q       <= 8'h00;
      x_q        <= '0;
      y_q        <= '0;
      guard_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      data_q     <= 16'h0000;
      px_q       <= '0;
      py_q       <= '0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      x_q        <= x_d;
      y_q        <= y_d;
      guard_q    <= guard_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      data_q     <= data_d;
      px_q       <= px_d;
      py_q       <= py_d;
    end
  end

  // FIFO pointer/occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= push_entry_s;
    end
  end

  assign spi_pixel_ready = ready_q;
  assign spi_pixel_data  = data_q;
  // Counters are unsigned; the extra sign bit is always zero.
  assign spi_pixel_x     = {1'b0, px_q};
  assign spi_pixel_y     = {1'b0, py_q};
  assign image_done      = done_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_spi_pixel_loader.sv
module tb_spi_pixel_loader;

  logic               clk;
  logic               rst_n;
  logic               spi_frame_start;
  logic               spi_byte_valid;
  logic [7:0]         spi_byte;
  logic               spi_pixel_ready;
  logic               spi_pixel_read;
  logic [15:0]        spi_pixel_data;
  logic signed [11:0] spi_pixel_x;
  logic signed [11:0] spi_pixel_y;
  logic               image_done;
  logic               overflow;

  int checks = 0;
  int errors = 0;

  spi_pixel_loader #(
    .X_RES(4), .Y_RES(2), .PRECISION(11), .FIFO_DEPTH(4), .ACK_GUARD(6)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_frame_start(spi_frame_start),
    .spi_byte_valid(spi_byte_valid),
    .spi_byte(spi_byte),
    .spi_pixel_ready(spi_pixel_ready),
    .spi_pixel_read(spi_pixel_read),
    .spi_pixel_data(spi_pixel_data),
    .spi_pixel_x(spi_pixel_x),
    .spi_pixel_y(spi_pixel_y),
    .image_done(image_done),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_byte_valid = 1'b1;
    spi_byte       = b;
    tick();
    spi_byte_valid = 1'b0;
  endtask

  task automatic frame_start();
    spi_frame_start = 1'b1;
    tick();
    spi_frame_start = 1'b0;
  endtask

  task automatic ack();
    spi_pixel_read = 1'b1;
    tick();
    spi_pixel_read = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!spi_pixel_ready && n < 40) begin
      tick();
      n++;
    end
    check_value({tag, " ready"}, 32'(spi_pixel_ready), 32'd1);
  endtask

  task automatic check_pixel(input string tag, input logic [15:0] d, input int x, input int y);
    check_value({tag, " data"}, 32'(spi_pixel_data), 32'(d));
    check_value({tag, " x"}, 32'($unsigned(spi_pixel_x)), 32'(x));
    check_value({tag, " y"}, 32'($unsigned(spi_pixel_y)), 32'(y));
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, " ready"}, 32'(spi_pixel_ready), 32'd0);
    check_value({tag, " data"}, 32'(spi_pixel_data), 32'd0);
    check_value({tag, " x"}, 32'($unsigned(spi_pixel_x)), 32'd0);
    check_value({tag, " y"}, 32'($unsigned(spi_pixel_y)), 32'd0);
    check_value({tag, " done"}, 32'(image_done), 32'd0);
    check_value({tag, " ovf"}, 32'(overflow), 32'd0);
  endtask

  // Raster coordinates for the 4x2 test image
  int exp_x [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_y [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    rst_n           = 1'b0;
    spi_frame_start = 1'b0;
    spi_byte_valid  = 1'b0;
    spi_byte        = 8'h00;
    spi_pixel_read  = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Bytes and acks before any frame start are ignored
    send_byte(8'h55);
    send_byte(8'h66);
    ack();
    repeat (4) tick();
    check_all_zero("idle");

    // Test 1: two pixels, acked 5 cycles after ready
    frame_start();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    wait_ready("t1 p0");
    check_pixel("t1 p0", 16'h1234, 0, 0);
    repeat (4) tick();
    check_value("t1 p0 held", 32'(spi_pixel_ready), 32'd1);
    check_pixel("t1 p0 stable", 16'h1234, 0, 0);
    ack();
    check_value("t1 p0 ack drop", 32'(spi_pixel_ready), 32'd0);
    tick();
    check_value("t1 p1 reappear", 32'(spi_pixel_ready), 32'd1);
    check_pixel("t1 p1", 16'h5678, 1, 0);
    repeat (4) tick();
    ack();
    check_value("t1 p1 ack drop", 32'(spi_pixel_ready), 32'd0);

    // Test 2: rest of the image, prompt acks, exact two-cycle latency
    for (int i = 2; i < 8; i++) begin
      send_byte(8'hC0 + 8'(i));
      send_byte(8'h0F + 8'(i));
      check_value("t2 latency low", 32'(spi_pixel_ready), 32'd0);
      tick();
      check_value("t2 latency high", 32'(spi_pixel_ready), 32'd1);
      check_pixel("t2 pix", {8'hC0 + 8'(i), 8'h0F + 8'(i)}, exp_x[i], exp_y[i]);
      check_value("t2 not done", 32'(image_done), 32'd0);
      ack();
    end
    check_value("t2 final drop", 32'(spi_pixel_ready), 32'd0);
    check_value("t2 done early", 32'(image_done), 32'd0);
    tick();
    check_value("t2 done", 32'(image_done), 32'd1);

    // Test 6: bytes in DONE and stray acks change nothing
    send_byte(8'hEE);
    send_byte(8'hFF);
    ack();
    repeat (4) tick();
    check_value("t6 done ready", 32'(spi_pixel_ready), 32'd0);
    check_value("t6 done kept", 32'(image_done), 32'd1);
    check_value("t6 done ovf", 32'(overflow), 32'd0);

    // Test 3: withhold acks, six pixels into 1 presented + 4 buffered
    frame_start();
    check_value("t3 done clr", 32'(image_done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'hA0 + 8'(i));
      send_byte(8'h10 + 8'(i));
      if (i == 4) check_value("t3 ovf before", 32'(overflow), 32'd0);
    end
    check_value("t3 ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) begin
      wait_ready("t3 drain");
      check_pixel("t3 drain", {8'hA0 + 8'(i), 8'h10 + 8'(i)}, exp_x[i], exp_y[i]);
      ack();
    end
    repeat (4) tick();
    check_value("t3 dropped", 32'(spi_pixel_ready), 32'd0);
    check_value("t3 ovf sticky", 32'(overflow), 32'd1);

    // Test 4: frame start while (2,0) is presented, stale ack in guard
    frame_start();
    check_value("t4 ovf clr", 32'(overflow), 32'd0);
    repeat (8) tick();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h30 + 8'(i));
      send_byte(8'h40 + 8'(i));
      wait_ready("t4 pre");
      check_pixel("t4 pre", {8'h30 + 8'(i), 8'h40 + 8'(i)}, exp_x[i], 0);
      if (i < 2) ack();
    end
    frame_start();
    check_value("t4 fs drop", 32'(spi_pixel_ready), 32'd0);
    send_byte(8'hAB);
    send_byte(8'hCD);
    ack();
    check_value("t4 stale ack", 32'(spi_pixel_ready), 32'd0);
    repeat (3) tick();
    check_value("t4 guard hold", 32'(spi_pixel_ready), 32'd0);
    tick();
    check_value("t4 guard end", 32'(spi_pixel_ready), 32'd1);
    check_pixel("t4 new", 16'hABCD, 0, 0);
    check_value("t4 ovf", 32'(overflow), 32'd0);
    ack();

    // Test 5: frame start and byte in the same cycle
    spi_frame_start = 1'b1;
    spi_byte_valid  = 1'b1;
    spi_byte        = 8'h99;
    tick();
    spi_frame_start = 1'b0;
    spi_byte_valid  = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    wait_ready("t5");
    check_pixel("t5", 16'h1122, 0, 0);

    // Test 6: asynchronous reset mid-presentation
    rst_n = 1'b0;
    #1;
    check_all_zero("async rst");
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_pixel_loader.md
Name: spi_pixel_loader

Overview:
- Producer side of the SPI image-write handshake (spi_pixel_ready / spi_pixel_read / spi_pixel_x / spi_pixel_y) consumed by the SRAM wrapper.
- Takes the byte stream from the SPI slave and assembles big-endian 16-bit pixels.
- Assigns raster coordinates starting at (0,0) and buffers pixels in a small FIFO.
- Presents one pixel at a time and holds it until the wrapper acknowledges the SRAM write.

Parameters:
X_RES, 800, image width in pixels; x wraps at X_RES-1
Y_RES, 600, image height; last pixel is (X_RES-1, Y_RES-1)
PRECISION, 11, coordinate ports are signed PRECISION+1 bits
FIFO_DEPTH, 4, pixel buffer entries (power of 2, >=2)
ACK_GUARD, 6, cycles after spi_frame_start during which spi_pixel_read is ignored (> wrapper SRAM delay of 5)

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
spi_frame_start  in  1  one-cycle pulse: new image begins (chip select asserted)
spi_byte_valid  in  1  one-cycle pulse: spi_byte holds a received byte
spi_byte  in  8  received byte
spi_pixel_ready  out  1  pixel and coordinates on outputs are valid
spi_pixel_read  in  1  one-cycle ack from wrapper: presented pixel written
spi_pixel_data  out  16  pixel value (to wrapper spi_pixel_in)
spi_pixel_x  out  PRECISION+1  signed x of presented pixel
spi_pixel_y  out  PRECISION+1  signed y of presented pixel
image_done  out  1  full image received and all pixels acknowledged
overflow  out  1  sticky: at least one pixel dropped because FIFO was full

Behaviour:
- Reset: assembler state IDLE, FIFO empty, coordinates 0, guard counter 0. All outputs 0: spi_pixel_ready, spi_pixel_data, spi_pixel_x, spi_pixel_y, image_done, overflow.
- Assembler FSM: IDLE, HI, LO, DONE.
  - IDLE: bytes ignored; spi_frame_start -> HI.
  - HI: on spi_byte_valid, latch the byte as the high byte -> LO.
  - LO: on spi_byte_valid, form pixel {hi, byte} at current (x,y).
    - If FIFO not full: push {pixel, x, y}.
    - If FIFO full: drop the pixel and set overflow.
    - In both cases coordinates advance: x+1, or x=0 and y+1 when x==X_RES-1.
    - If the pixel was (X_RES-1, Y_RES-1): -> DONE. Otherwise -> HI.
  - DONE: bytes ignored until the next spi_frame_start.
- spi_frame_start in any state, including while a pixel is presented:
  - Flush the FIFO, clear x/y, clear overflow and image_done.
  - Drop spi_pixel_ready the next cycle.
  - Load the guard counter with ACK_GUARD, then -> HI.
  - If spi_byte_valid arrives in the same cycle, the byte is discarded; frame_start wins.
- Output stage:
  - Pop and present the FIFO head when spi_pixel_ready is 0, the FIFO is non-empty and the guard counter is 0. The registered outputs spi_pixel_ready/data/x/y are valid the following cycle.
  - Pixel, x and y stay stable while spi_pixel_ready=1.
  - On spi_pixel_read=1 while spi_pixel_ready=1 and guard==0: spi_pixel_ready=0 the next cycle, for a minimum 1 idle cycle. The next pixel can appear at the earliest 2 cycles after the ack.
  - spi_pixel_read while spi_pixel_ready=0, or while guard>0, is ignored; stale acks from a flushed frame are swallowed this way.
- Latency: last byte of a pixel with FIFO empty and not presenting -> spi_pixel_ready high 2 cycles later.
- FIFO: a push and a pop in the same cycle are both permitted. "Full" counts occupancy before the pop, so no bypass.
- image_done = (state==DONE) & FIFO empty & ~spi_pixel_ready, registered. Cleared by spi_frame_start or reset.
- overflow: sticky until spi_frame_start or reset.
- Coordinates are unsigned counters zero-extended into the signed PRECISION+1 ports, so they are never negative.
- Reset mid-handshake: outputs go to 0 immediately (asynchronous).

Test Plan:
1. X_RES=4, Y_RES=2, frame_start, bytes 12 34 56 78; ack each pixel 5 cycles after ready -> (0,0)=0x1234, (1,0)=0x5678 presented in order; each ready held until ack, then low for >=1 cycle.
2. Full 8-pixel image, prompt acks -> last pixel at x=3, y=1; coordinates wrap x 3->0 with y 0->1; image_done=1 one cycle after the final ack clears ready.
3. Withhold acks, send 6 pixels with FIFO_DEPTH=4 -> 1 presented + 4 buffered; 6th pixel dropped, overflow=1; subsequent acks drain 5 pixels with coordinates (0,0)..(0,1), (1,1) skipped.
4. frame_start while pixel (2,0) is presented, ack pulse 3 cycles later, new bytes AB CD immediately -> stale ack ignored; 0xABCD at (0,0) appears only after the 6-cycle guard; overflow cleared.
5. frame_start and spi_byte_valid in the same cycle, then bytes 11 22 -> first byte discarded; pixel 0x1122 at (0,0).
6. Bytes sent in DONE, or before any frame_start, and spi_pixel_read pulses while ready=0 -> no pixels, no state change; rst_n low mid-presentation -> all outputs 0 asynchronously.
